link_frame_codec: RTL and testbench

- Framing stage between the local player's 8-bit status byte (score-key, reset, menu-start and d_position fields) and the UART FIFO wrapper (uart_ff_buf).
- TX side: periodically snapshots the local byte and emits a 3-byte frame (SYNC, DATA, CHK).
- RX side: hunts for frames in the received byte stream, validates them, and presents the peer's status byte.
- Also reports whether the link is alive and counts corrupted frames. Replaces the unframed p1_and_p2_data exchange.

---
 rtl/link_frame_codec.sv | 122 ++++++++++++
 tb/tb_link_frame_codec.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/link_frame_codec.sv
// link_frame_codec: frames the local status byte into SYNC/DATA/CHK for the UART TX FIFO and
// hunts, validates and reports peer frames from the RX FIFO, with link-alive and error tracking.
module link_frame_codec #(
  parameter int unsigned SEND_PERIOD    = 65000,
  parameter int unsigned TIMEOUT_FRAMES = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] local_data,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] peer_data,
  output logic       peer_valid,
  output logic       link_up,
  output logic [7:0] err_count
);
  localparam int unsigned CW = (SEND_PERIOD > 1) ? $clog2(SEND_PERIOD) : 1;
  localparam logic [7:0]  TF = 8'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {IDLE, S_SYNC, S_DATA, S_CHK} tx_state_e;
  typedef enum logic [1:0] {HUNT, R_DATA, R_CHK} rx_state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  tx_state_e     tx_q, tx_d;
  logic [7:0]    snap_q, snap_d;
  logic          pend_q, pend_d;
  rx_state_e     rx_q, rx_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    peer_q, peer_d;
  logic          pv_q, pv_d;
  logic          link_q, link_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    to_q, to_d, to_inc;
  logic          accept, bad;

  assign tick  = cnt_q == CW'(SEND_PERIOD - 1);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    tx_d    = tx_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    wr_uart = tx_q != IDLE && !tx_full;
    w_data  = tx_q == S_SYNC ? SYNC_BYTE : tx_q == S_DATA ? snap_q : tx_q == S_CHK ? ~snap_q : 8'h00;
    if (tx_q == IDLE) begin
      if (tick || pend_q) begin
        snap_d = local_data;
        pend_d = 1'b0;
        tx_d   = S_SYNC;
      end
    end else begin
      if (tick) pend_d = 1'b1;
      if (!tx_full) tx_d = tx_q == S_SYNC ? S_DATA : tx_q == S_DATA ? S_CHK : IDLE;
    end
  end

  // rd_uart is gated by reset so nothing is popped while the block is held in reset
  always_comb begin
    rx_d    = rx_q;
    dat_d   = dat_q;
    accept  = 1'b0;
    bad     = 1'b0;
    rd_uart = rst && !rx_empty;
    if (!rx_empty) begin
      if (rx_q == HUNT) begin
        rx_d = r_data == SYNC_BYTE ? R_DATA : HUNT;
      end else if (rx_q == R_DATA) begin
        dat_d = r_data;
        rx_d  = R_CHK;
      end else begin
        accept = r_data == ~dat_q;
        bad    = !accept;
        rx_d   = HUNT;
      end
    end
    peer_d = accept ? dat_q : peer_q;
    pv_d   = accept;
    err_d  = bad && err_q != 8'hFF ? err_q + 8'd1 : err_q;
    to_inc = to_q == TF ? to_q : to_q + 8'd1;
    to_d   = accept ? 8'd0 : tick ? to_inc : to_q;
    link_d = accept ? 1'b1 : (tick && to_inc == TF) ? 1'b0 : link_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tx_q   <= IDLE;
      snap_q <= 8'h00;
      pend_q <= 1'b0;
      rx_q   <= HUNT;
      dat_q  <= 8'h00;
      peer_q <= 8'h00;
      pv_q   <= 1'b0;
      link_q <= 1'b0;
      err_q  <= 8'h00;
      to_q   <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      tx_q   <= tx_d;
      snap_q <= snap_d;
      pend_q <= pend_d;
      rx_q   <= rx_d;
      dat_q  <= dat_d;
      peer_q <= peer_d;
      pv_q   <= pv_d;
      link_q <= link_d;
      err_q  <= err_d;
      to_q   <= to_d;
    end
  end

  assign peer_data  = peer_q;
  assign peer_valid = pv_q;
  assign link_up    = link_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_link_frame_codec.sv
// tb_link_frame_codec: randomized and directed stimulus checked every cycle against a
// queue-based frame model (expected TX byte queue, RX byte window, tick arithmetic).
module tb_link_frame_codec;
  localparam int         P  = 8;
  localparam int         TF = 2;
  localparam logic [7:0] SB = 8'hA5;

  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] local_data = 8'h00, r_data = 8'h00;
  logic       tx_full = 1'b0, rx_empty = 1'b1;
  logic       wr_uart, rd_uart, peer_valid, link_up;
  logic [7:0] w_data, peer_data, err_count;

  link_frame_codec #(.SEND_PERIOD(P), .TIMEOUT_FRAMES(TF), .SYNC_BYTE(SB)) dut (
    .clk(clk), .rst(rst), .local_data(local_data), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .peer_data(peer_data), .peer_valid(peer_valid),
    .link_up(link_up), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  logic [7:0] txq[$];
  logic [7:0] win[$];
  logic [7:0] rxs[$];
  bit         pend, ever, m_pv, m_link;
  logic [7:0] m_peer;
  int         m_err, since, n;

  task automatic model_reset();
    txq.delete(); win.delete();
    pend = 0; ever = 0; m_pv = 0; m_link = 0; m_peer = 8'h00;
    m_err = 0; since = 0; n = 0;
  endtask

  // one clock cycle, entered and left at a negedge
  task automatic cycle(input logic tf, input logic re, input logic [7:0] rd, input logic [7:0] ld);
    bit tick, busy, acc;
    check("peer_valid", peer_valid, m_pv);
    check("peer_data", peer_data, m_peer);
    check("link_up", link_up, m_link);
    check("err_count", err_count, 8'(m_err));
    tx_full = tf; rx_empty = re; r_data = rd; local_data = ld;
    #1;
    tick = (n % P) == P - 1;
    busy = txq.size() != 0;
    check("wr_uart", wr_uart, busy && !tf);
    if (busy) check("w_data", w_data, txq[0]);
    check("rd_uart", rd_uart, !re);
    if (!busy) begin
      if (tick || pend) begin
        txq.push_back(SB); txq.push_back(ld); txq.push_back(~ld);
        pend = 0;
      end
    end else begin
      if (tick) pend = 1;
      if (!tf) void'(txq.pop_front());
    end
    acc = 0;
    if (!re) begin
      win.push_back(rd);
      while (win.size() > 0 && win[0] != SB) void'(win.pop_front());
      if (win.size() == 3) begin
        if (win[2] == ~win[1]) begin acc = 1; m_peer = win[1]; end
        else if (m_err < 255) m_err++;
        win.delete();
      end
    end
    m_pv = acc;
    if (acc) begin ever = 1; since = 0; end
    else if (tick) since++;
    m_link = ever && since < TF;
    n++;
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b0; rx_empty = 1'b0;
    #1;
    check("rst_wr_uart", wr_uart, 0);
    check("rst_w_data", w_data, 0);
    check("rst_rd_uart", rd_uart, 0);
    check("rst_peer_data", peer_data, 0);
    check("rst_peer_valid", peer_valid, 0);
    check("rst_link_up", link_up, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; rx_empty = 1'b1;
    model_reset();
  endtask

  task automatic push_frame(input logic [7:0] d, input bit good);
    rxs.push_back(SB); rxs.push_back(d); rxs.push_back(good ? ~d : d ^ 8'h01);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_mid();
    for (int i = 0; i < 30; i++) cycle(0, 1, 8'h00, 8'h3C);
    for (int i = 0; i < 20 && txq.size() != 2; i++) cycle(0, 1, 8'h00, 8'h3C);
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'h00, 8'h3C);
    for (int i = 0; i < 20 && txq.size() != 2; i++) cycle(0, 1, 8'h00, 8'h3C);
    for (int i = 0; i < 18; i++) cycle(1, 1, 8'h00, 8'h77);
    for (int i = 0; i < 30; i++) cycle(0, 1, 8'h00, 8'h55);
    foreach (rxs[i]) ;
    cycle(0, 0, 8'h00, 8'h11); cycle(0, 0, 8'hA5, 8'h11);
    cycle(0, 0, 8'hA5, 8'h11); cycle(0, 0, 8'h5A, 8'h11);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, 8'h11);
    for (int k = 0; k < 300; k++) begin
      cycle(0, 0, 8'hA5, 8'h22); cycle(0, 0, 8'h12, 8'h22); cycle(0, 0, 8'h12, 8'h22);
    end
    cycle(0, 0, 8'hA5, 8'h22); cycle(0, 0, 8'h40, 8'h22); cycle(0, 0, 8'hBF, 8'h22);
    for (int i = 0; i < 30; i++) cycle(0, 1, 8'h00, 8'h33);
    for (int i = 0; i < 20 && txq.size() != 2; i++) cycle(0, 1, 8'h00, 8'h44);
    cycle(0, 0, 8'hA5, 8'h44); cycle(0, 0, 8'h33, 8'h44);
    reset_mid();
    cycle(0, 0, 8'hCC, 8'h66);
    cycle(0, 0, 8'hA5, 8'h66); cycle(0, 0, 8'h44, 8'h66); cycle(0, 0, 8'hBB, 8'h66);
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'h00, 8'h99);
    for (int c = 0; c < 4000; c++) begin
      bit quiet, re;
      quiet = (c % 500) >= 440;
      if (rxs.size() == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: push_frame(8'($urandom), 1);
          5, 6:          push_frame(8'($urandom), 0);
          7:             rxs.push_back(SB);
          default:       rxs.push_back(8'($urandom));
        endcase
      end
      re = quiet || $urandom_range(0, 2) == 0;
      cycle($urandom_range(0, 3) == 0, re, re ? 8'($urandom) : rxs[0], 8'($urandom));
      if (!re) void'(rxs.pop_front());
      if (c == 2345) begin reset_mid(); rxs.delete(); end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
